// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage MIPS pipeline.
//
// Sits between the ex_mem and mem_wb pipeline registers. Non-memory results
// pass straight through. Loads and stores are carried out over a req/ack
// data bus with big-endian byte-lane alignment, sign/zero extension of load
// data, misalignment detection and a bus timeout. While a bus transaction
// is pending, stallreq is raised so the pipeline controller freezes ex_mem
// and everything upstream of it.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ex_wd/ex_wreg/ex_wdata   destination, write enable, ALU result from ex_mem
//   ex_mem_op         memory op (1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 8 SB,
//                     9 SH, 10 SW, anything else = none)
//   ex_mem_addr       effective byte address
//   ex_reg2           store data (rt)
//   mem_wd/mem_wreg/mem_wdata  results towards mem_wb
//   stallreq          stall request to the pipeline controller
//   bus_req/bus_we/bus_addr/bus_sel/bus_wdata  registered bus request side
//   bus_rdata/bus_ack read data and transfer-complete from the bus
//   align_err         one-cycle pulse after a misaligned access
//   bus_err           one-cycle pulse after a bus timeout
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [31:0]   load_data;
  logic          abort;
  logic [3:0]    op_q;
  logic [1:0]    addr_lo_q;

  logic          is_load;
  logic          is_store;
  logic          is_byte;
  logic          is_half;
  logic          misaligned;
  logic          mem_go;
  logic [3:0]    sel_next;
  logic [31:0]   wdata_next;
  logic          op_q_is_load;
  logic          req_last;

  // Selects the addressed byte/halfword (big-endian lanes) and extends it.
  function automatic logic [31:0] extract_load(input logic [3:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = lo[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Decode of the incoming op: access size, lane enables, store data and
  // alignment. misaligned is only ever set for real memory ops.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_byte    = 1'b0;
    is_half    = 1'b0;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; end
      OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; end
      default:       begin end
    endcase

    if (is_byte) begin
      sel_next = 4'b1000 >> ex_mem_addr[1:0];
    end else if (is_half) begin
      sel_next = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
    end else begin
      sel_next = 4'b1111;
    end

    if (!is_store) begin
      wdata_next = 32'd0;
    end else if (is_byte) begin
      wdata_next = {4{ex_reg2[7:0]}};
    end else if (is_half) begin
      wdata_next = {2{ex_reg2[15:0]}};
    end else begin
      wdata_next = ex_reg2;
    end

    if (!(is_load || is_store)) begin
      misaligned = 1'b0;
    end else if (is_half) begin
      misaligned = ex_mem_addr[0];
    end else if (!is_byte) begin
      misaligned = (ex_mem_addr[1:0] != 2'b00);
    end else begin
      misaligned = 1'b0;
    end

    mem_go = (is_load || is_store) && !misaligned;
  end

  assign op_q_is_load = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_LH) ||
                        (op_q == OP_LHU) || (op_q == OP_LW);
  assign req_last     = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_go) state_next = REQ;
      REQ:     if (bus_ack || req_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writeback-side outputs. The IDLE cycle of an aligned access is already
  // a stall with a bubble; DONE releases the stall and hands over the load.
  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq  = 1'b0;
    case (state)
      IDLE: begin
        if (misaligned) mem_wreg = 1'b0;
        if (mem_go) begin
          stallreq = 1'b1;
          mem_wreg = 1'b0;
        end
      end
      REQ: begin
        stallreq = 1'b1;
        mem_wreg = 1'b0;
      end
      DONE: begin
        if (op_q_is_load) begin
          mem_wreg  = ex_wreg & ~abort;
          mem_wdata = load_data;
        end else begin
          mem_wreg  = 1'b0;
        end
      end
      default: begin
        mem_wreg = 1'b0;
      end
    endcase
    if (rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
      stallreq  = 1'b0;
    end
  end

  // Bus request registers, timeout counter and load capture. The error
  // pulses default low so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      load_data <= 32'd0;
      abort     <= 1'b0;
      op_q      <= 4'd0;
      addr_lo_q <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_go) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {ex_mem_addr[31:2], 2'b00};
            bus_sel   <= sel_next;
            bus_wdata <= wdata_next;
            cnt       <= '0;
            abort     <= 1'b0;
            op_q      <= ex_mem_op;
            addr_lo_q <= ex_mem_addr[1:0];
          end else if (misaligned) begin
            align_err <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ack) begin
            load_data <= extract_load(op_q, addr_lo_q, bus_rdata);
            bus_req   <= 1'b0;
          end else if (req_last) begin
            load_data <= 32'd0;
            abort     <= 1'b1;
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          abort <= 1'b0;
        end
        default: begin end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage (TIMEOUT=4).
// Drives inputs just after the falling edge, samples 1ns later, and plays
// the bus slave itself by raising bus_ack after a chosen number of waits.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        align_err;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  // Observations gathered by applyStimulus for one transaction.
  int          obsStall;
  int          obsReq;
  logic [31:0] obsAddr;
  logic [3:0]  obsSel;
  logic        obsWe;
  logic [31:0] obsWdata;
  logic [31:0] obsDoneData;
  logic        obsDoneWreg;
  logic        obsBusErr;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one aligned memory op to completion. waitCycles = REQ cycles
  // without ack before ack is given; negative means never ack.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] reg2, input logic [4:0] wd,
                               input logic wreg, input int waitCycles,
                               input logic [31:0] rdata);
    bit sawStall = 0;
    bit done     = 0;
    obsStall = 0; obsReq = 0;
    obsAddr = '0; obsSel = '0; obsWe = 1'b0; obsWdata = '0;
    obsDoneData = '0; obsDoneWreg = 1'b0; obsBusErr = 1'b0;
    @(negedge clk);
    ex_mem_op = op; ex_mem_addr = addr; ex_reg2 = reg2;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = 32'h5555_AAAA;
    bus_rdata = 32'hDEAD_0000;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (stallreq) begin
        obsStall++;
        sawStall = 1;
      end
      if (bus_req) begin
        obsReq++;
        if (obsReq == 1) begin
          obsAddr = bus_addr; obsSel = bus_sel; obsWe = bus_we; obsWdata = bus_wdata;
        end
        if (waitCycles >= 0 && obsReq == waitCycles + 1) begin
          bus_ack = 1'b1; bus_rdata = rdata;
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        bus_ack = 1'b0;
      end
      if (sawStall && !stallreq) begin
        obsDoneData = mem_wdata;
        obsDoneWreg = mem_wreg;
        obsBusErr   = bus_err;
        done = 1;
        ex_mem_op = 4'd0;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      checkOutput("txnFinished", 32'd0, 32'd1);
      ex_mem_op = 4'd0;
      bus_ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
    ex_mem_op = 4'd0; ex_mem_addr = '0; ex_reg2 = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // Reset state: outputs forced low while rst is high.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstMemWd",    32'(mem_wd),    32'd0);
    checkOutput("rstMemWreg",  32'(mem_wreg),  32'd0);
    checkOutput("rstMemWdata", mem_wdata,      32'd0);
    checkOutput("rstStall",    32'(stallreq),  32'd0);
    checkOutput("rstBusReq",   32'(bus_req),   32'd0);
    checkOutput("rstBusSel",   32'(bus_sel),   32'd0);
    checkOutput("rstAlignErr", 32'(align_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory op passes through; a stray ack is ignored.
    @(negedge clk);
    ex_mem_op = 4'd0; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
    bus_ack = 1'b1;
    #1;
    checkOutput("passWd",    32'(mem_wd),   32'd5);
    checkOutput("passWreg",  32'(mem_wreg), 32'd1);
    checkOutput("passWdata", mem_wdata,     32'h1234);
    checkOutput("passStall", 32'(stallreq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("passNoReq", 32'(bus_req), 32'd0);
    end
    bus_ack = 1'b0;

    // LB 0x101: lane 0100, sign-extended 0xAA.
    applyStimulus(4'd1, 32'h101, 32'h0, 5'd7, 1'b1, 0, 32'h11AA2233);
    checkOutput("lbAddr",  obsAddr,             32'h100);
    checkOutput("lbSel",   32'(obsSel),         32'b0100);
    checkOutput("lbWe",    32'(obsWe),          32'd0);
    checkOutput("lbStall", 32'(obsStall),       32'd2);
    checkOutput("lbData",  obsDoneData,         32'hFFFFFFAA);
    checkOutput("lbWreg",  32'(obsDoneWreg),    32'd1);

    // LBU 0x101: zero-extended.
    applyStimulus(4'd2, 32'h101, 32'h0, 5'd7, 1'b1, 0, 32'h11AA2233);
    checkOutput("lbuData", obsDoneData, 32'h000000AA);

    // LH / LHU on the low halfword.
    applyStimulus(4'd3, 32'h102, 32'h0, 5'd8, 1'b1, 0, 32'h12348001);
    checkOutput("lhSel",   32'(obsSel), 32'b0011);
    checkOutput("lhData",  obsDoneData, 32'hFFFF8001);
    applyStimulus(4'd4, 32'h102, 32'h0, 5'd8, 1'b1, 0, 32'h12348001);
    checkOutput("lhuData", obsDoneData, 32'h00008001);

    // SH 0x202, ack after 3 waits (last cycle before timeout).
    applyStimulus(4'd9, 32'h202, 32'h0000BEEF, 5'd9, 1'b1, 3, 32'h0);
    checkOutput("shWe",    32'(obsWe),       32'd1);
    checkOutput("shSel",   32'(obsSel),      32'b0011);
    checkOutput("shWdata", obsWdata,         32'hBEEFBEEF);
    checkOutput("shStall", 32'(obsStall),    32'd5);
    checkOutput("shWreg",  32'(obsDoneWreg), 32'd0);
    checkOutput("shBusErr", 32'(obsBusErr),  32'd0);

    // SB 0x203: last lane, replicated byte.
    applyStimulus(4'd8, 32'h203, 32'h12345678, 5'd0, 1'b0, 0, 32'h0);
    checkOutput("sbAddr",  obsAddr,     32'h200);
    checkOutput("sbSel",   32'(obsSel), 32'b0001);
    checkOutput("sbWdata", obsWdata,    32'h78787878);

    // Misaligned LW 0x302.
    @(negedge clk);
    ex_mem_op = 4'd5; ex_mem_addr = 32'h302; ex_wd = 5'd3; ex_wreg = 1'b1;
    ex_wdata = 32'hABCD;
    #1;
    checkOutput("misWreg",  32'(mem_wreg), 32'd0);
    checkOutput("misWd",    32'(mem_wd),   32'd3);
    checkOutput("misWdata", mem_wdata,     32'hABCD);
    checkOutput("misStall", 32'(stallreq), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("misAlignErr", 32'(align_err), 32'd1);
    checkOutput("misNoReq",    32'(bus_req),   32'd0);
    ex_mem_op = 4'd0;
    @(negedge clk);
    #1;
    checkOutput("misAlignErrEnd", 32'(align_err), 32'd0);

    // LW timeout: 4 REQ cycles, bus_err pulse, no writeback.
    applyStimulus(4'd5, 32'h300, 32'h0, 5'd4, 1'b1, -1, 32'h0);
    checkOutput("toReq",    32'(obsReq),      32'd4);
    checkOutput("toStall",  32'(obsStall),    32'd5);
    checkOutput("toBusErr", 32'(obsBusErr),   32'd1);
    checkOutput("toWreg",   32'(obsDoneWreg), 32'd0);
    checkOutput("toData",   obsDoneData,      32'd0);
    @(negedge clk);
    #1;
    checkOutput("toBusErrEnd", 32'(bus_err), 32'd0);
    checkOutput("toReqEnd",    32'(bus_req), 32'd0);

    // Reset while in REQ, then a clean LW.
    @(negedge clk);
    ex_mem_op = 4'd5; ex_mem_addr = 32'h400; ex_wd = 5'd6; ex_wreg = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rmReqUp", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rmReq",   32'(bus_req),  32'd0);
    checkOutput("rmStall", 32'(stallreq), 32'd0);
    ex_mem_op = 4'd0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rmIdleReq",   32'(bus_req),  32'd0);
    checkOutput("rmIdleStall", 32'(stallreq), 32'd0);
    applyStimulus(4'd5, 32'h404, 32'h0, 5'd6, 1'b1, 1, 32'hCAFEF00D);
    checkOutput("lwAddr",  obsAddr,          32'h404);
    checkOutput("lwSel",   32'(obsSel),      32'b1111);
    checkOutput("lwStall", 32'(obsStall),    32'd3);
    checkOutput("lwData",  obsDoneData,      32'hCAFEF00D);
    checkOutput("lwWreg",  32'(obsDoneWreg), 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline; sits between the ex_mem pipeline register and the mem_wb register.
- Passes non-memory results through unchanged.
- Executes loads and stores over a req/ack data bus, with byte-lane alignment, sign/zero extension, timeout and misalignment detection.
- Asserts stallreq while a bus transaction is pending, so the pipeline controller freezes ex_mem and upstream stages.

Parameters:
- TIMEOUT, 16: maximum REQ-state cycles waiting for bus_ack before abort (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_wd  in  5  destination register from ex_mem
- ex_wreg  in  1  write-enable from ex_mem
- ex_wdata  in  32  ALU result from ex_mem
- ex_mem_op  in  4  memory op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 8 SB, 9 SH, 10 SW; any other value = none
- ex_mem_addr  in  32  effective byte address
- ex_reg2  in  32  store data (rt)
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- stallreq  out  1  stall request to pipeline controller
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  32  word address {addr[31:2],2'b00}, registered
- bus_sel  out  4  byte enables, bit3 = bits 31:24, registered
- bus_wdata  out  32  write data, registered
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transfer complete
- align_err  out  1  one-cycle misalignment pulse, registered
- bus_err  out  1  one-cycle timeout pulse, registered

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, timeout counter=0, load-data register=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, align_err=0, bus_err=0.
  - While rst=1: mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0.
  - Reset mid-transaction abandons it; bus_req is low after that edge.
- Byte order: big-endian.
  - Byte at addr[1:0]=00 occupies bits 31:24.
  - SB sel: 1000/0100/0010/0001; wdata={4{reg2[7:0]}}.
  - SH sel: 1100 (addr[1]=0) or 0011 (addr[1]=1); wdata={2{reg2[15:0]}}.
  - SW sel: 1111; wdata=reg2.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠00.
  - No bus access; no stall.
  - mem_wreg=0, mem_wd=ex_wd, mem_wdata=ex_wdata.
  - align_err=1 for the following cycle.
- States: IDLE, REQ, DONE.
- IDLE:
  - Op none or misaligned: outputs driven combinationally (mem_wd=ex_wd, mem_wreg=ex_wreg unless misaligned, mem_wdata=ex_wdata); stallreq=0; stay IDLE.
  - Aligned memory op: stallreq=1, mem_wreg=0 (bubble). Next edge: register bus_req=1, we/addr/sel/wdata; counter=0; go REQ.
- REQ:
  - Bus signals held stable; stallreq=1; mem_wreg=0.
  - bus_ack=1 at edge: capture the extracted/extended load value; bus_req→0; go DONE.
  - No ack with counter=TIMEOUT-1: bus_req→0; bus_err pulse; go DONE with the abort flag set.
  - Otherwise counter+1.
- DONE:
  - stallreq=0; mem_wd=ex_wd.
  - Load: mem_wreg=ex_wreg & ~abort; mem_wdata=captured value (0 if aborted).
  - Store: mem_wreg=0.
  - Next edge: go IDLE, clear abort.
- Load extension: LB sign-extends the selected byte; LBU zero-extends; LH/LHU likewise for the halfword; LW is the full word.
- Latency: memory op with ack in the first REQ cycle occupies 3 cycles (IDLE, REQ, DONE); each extra wait cycle adds 1.
- bus_ack outside REQ is ignored.
- ex_* inputs are held stable by upstream while stallreq=1.

Test Plan:
- ex_mem_op=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 → same cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234; stallreq=0; bus_req never rises.
- LB addr 0x101, bus_rdata=0x11AA2233, ack on first REQ cycle:
  - bus_sel=0100, bus_addr=0x100, bus_we=0.
  - stallreq high for exactly 2 cycles.
  - DONE cycle: mem_wdata=0xFFFFFFAA, mem_wreg=1.
  - Repeat with LBU → 0x000000AA.
- SH addr 0x202, reg2=0x0000BEEF:
  - bus_we=1, bus_sel=0011, bus_wdata=0xBEEFBEEF.
  - Ack after 3 wait cycles → stallreq high 5 cycles; DONE mem_wreg=0.
- LW addr 0x302 → no bus_req; align_err pulses 1 cycle; mem_wreg=0; stallreq=0.
- LW with TIMEOUT=4, no ack:
  - bus_req high exactly 4 cycles, then bus_err pulse.
  - DONE: mem_wreg=0, mem_wdata=0.
- LW in REQ, rst asserted for one edge → bus_req=0, stallreq=0, state IDLE; a subsequent LW completes normally.
